// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan controller for a 4-digit 7-segment display.
//   A 16-bit value is captured on a load strobe into a pending buffer. It is
//   copied into the shadow (displayed) register only at a frame boundary, so
//   the displayed value never changes mid-frame. Each digit slot starts with
//   a blanking interval (all anodes off) to prevent ghosting. Leading zero
//   digits can optionally be suppressed.
//
// Parameters
//   DIGIT_TICKS  clk cycles per digit slot (>= 2)
//   BLANK_TICKS  cycles at the start of each slot with all anodes off
//                (0 .. DIGIT_TICKS-1; 0 means no blanking)
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   dato_reg     value to display: [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   dp_ce        load strobe; dato_reg is sampled on each rising edge where it is high
//   lz_blank_en  1 = suppress leading zero digits (sampled every cycle)
//   an_o         anode select, active low: one bit low, or 4'b1111 when off
//   digit_o      nibble for the current slot, to the segment decoder
//   dig_valid    1 while an_o drives a digit
//   frame_start  1-cycle pulse on the first cycle of slot 0
module display_scan_controller #(
  parameter int DIGIT_TICKS = 10000,
  parameter int BLANK_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dato_reg,
  input  logic        dp_ce,
  input  logic        lz_blank_en,
  output logic [3:0]  an_o,
  output logic [3:0]  digit_o,
  output logic        dig_valid,
  output logic        frame_start
);

  localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] TERM_C  = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_TICKS);

  typedef enum logic {PH_BLANK, PH_ON} phase_e;

  // Scan state
  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_v_q, pend_v_d;
  logic [15:0]   shadow_q, shadow_d;

  // Registered outputs
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;
  logic          dig_valid_q, dig_valid_d;
  logic          frame_start_q, frame_start_d;

  logic          frame_edge;
  logic          in_blank;
  logic          suppress;
  logic [3:0]    nib_zero;
  phase_e        phase_d;

  // Next-state: prescaler, slot index and double-buffered value.
  // run_q holds the counter at (0,0) on the first edge after reset release,
  // so that edge loads the outputs for slot 0 / cnt 0 and frame_start fires
  // on the first cycle after release.
  always_comb begin
    run_d      = 1'b1;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    pend_v_d   = pend_v_q;
    shadow_d   = shadow_q;
    frame_edge = 1'b0;

    if (run_q) begin
      if (cnt_q == TERM_C) begin
        cnt_d      = '0;
        idx_d      = idx_q + 2'd1;
        frame_edge = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (frame_edge) begin
      // A strobe on the boundary edge itself is newer than anything pending.
      if (dp_ce) begin
        shadow_d = dato_reg;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pending_q;
        pend_v_d = 1'b0;
      end
    end else if (dp_ce) begin
      pending_d = dato_reg;
      pend_v_d  = 1'b1;
    end
  end

  generate
    if (BLANK_TICKS == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_d < BLANK_C);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (shadow_d[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    suppress = 1'b0;
    if (lz_blank_en) begin
      case (idx_d)
        2'd1:    suppress = nib_zero[1] & nib_zero[2] & nib_zero[3];
        2'd2:    suppress = nib_zero[2] & nib_zero[3];
        2'd3:    suppress = nib_zero[3];
        default: suppress = 1'b0;
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with it.
  always_comb begin
    phase_d       = in_blank ? PH_BLANK : PH_ON;
    digit_d       = shadow_d[{idx_d, 2'b00} +: 4];
    frame_start_d = (idx_d == 2'd0) && (cnt_d == '0);
    an_d          = 4'b1111;
    dig_valid_d   = 1'b0;
    if ((phase_d == PH_ON) && !suppress) begin
      an_d        = ~(4'b0001 << idx_d);
      dig_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      pending_q     <= 16'd0;
      pend_v_q      <= 1'b0;
      shadow_q      <= 16'd0;
      an_q          <= 4'b1111;
      digit_q       <= 4'd0;
      dig_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      pend_v_q      <= pend_v_d;
      shadow_q      <= shadow_d;
      an_q          <= an_d;
      digit_q       <= digit_d;
      dig_valid_q   <= dig_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_o        = an_q;
  assign digit_o     = digit_q;
  assign dig_valid   = dig_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Two instances share all inputs: dut_a (DIGIT_TICKS=8, BLANK_TICKS=2) and
//   dut_b (DIGIT_TICKS=8, BLANK_TICKS=0). A queue holds the value each frame
//   is expected to show; every frame is checked cycle by cycle against a
//   small behavioural model of the scan pattern.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dato_reg;
  logic        dp_ce;
  logic        lz_blank_en;

  logic [3:0]  an_a, digit_a, an_b, digit_b;
  logic        valid_a, fs_a, valid_b, fs_b;

  int total = 0;
  int bad   = 0;
  int frame_no = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  display_scan_controller #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .dato_reg(dato_reg), .dp_ce(dp_ce),
    .lz_blank_en(lz_blank_en), .an_o(an_a), .digit_o(digit_a),
    .dig_valid(valid_a), .frame_start(fs_a)
  );

  display_scan_controller #(.DIGIT_TICKS(8), .BLANK_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .dato_reg(dato_reg), .dp_ce(dp_ce),
    .lz_blank_en(lz_blank_en), .an_o(an_b), .digit_o(digit_b),
    .dig_valid(valid_b), .frame_start(fs_b)
  );

  // {frame_start, dig_valid, an_o, digit_o} for frame cycle k
  function automatic logic [9:0] model(input logic [15:0] v, input logic lz,
                                       input int bt, input int k);
    int idx = k / 8;
    int cnt = k % 8;
    logic [3:0] nib = v[idx*4 +: 4];
    logic sup = lz && (idx > 0) && ((v >> (4*idx)) == 16'd0);
    logic on = (cnt >= bt) && !sup;
    return {(k == 0), on, (on ? ~(4'b0001 << idx) : 4'b1111), nib};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of frame cycle 0. Checks n cycles of both DUTs and
  // drives up to two load strobes (at index -1 = none). After a full frame the
  // value the next frame must show is pushed to the queue.
  task automatic run_frame(input logic lz, input int n,
                           input int l1_at, input logic [15:0] l1_v,
                           input int l2_at, input logic [15:0] l2_v);
    logic [15:0] val;
    logic [15:0] next_val;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
      val = 16'd0;
    end else begin
      val = exp_q.pop_front();
    end
    next_val = val;
    lz_blank_en = lz;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("f%0d_k%0d_a", frame_no, k), {22'd0, fs_a, valid_a, an_a, digit_a},
          {22'd0, model(val, lz, 2, k)});
      chk($sformatf("f%0d_k%0d_b", frame_no, k), {22'd0, fs_b, valid_b, an_b, digit_b},
          {22'd0, model(val, lz, 0, k)});
      if (k == l1_at) begin
        dp_ce = 1'b1; dato_reg = l1_v; next_val = l1_v;
      end else if (k == l2_at) begin
        dp_ce = 1'b1; dato_reg = l2_v; next_val = l2_v;
      end else begin
        dp_ce = 1'b0; dato_reg = 16'hDEAD;
      end
      @(negedge clk);
    end
    if (n == 32) exp_q.push_back(next_val);
    frame_no++;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; dp_ce = 1'b0; dato_reg = 16'd0; lz_blank_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", {22'd0, fs_a, valid_a, an_a, digit_a}, {22'd0, 10'b0_0_1111_0000});
    chk("reset_b", {22'd0, fs_b, valid_b, an_b, digit_b}, {22'd0, 10'b0_0_1111_0000});
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(16'h0000);

    // Load 1234 mid-frame: this frame still shows 0, next frame 1234
    run_frame(1'b0, 32, 10, 16'h1234, -1, 16'h0);
    run_frame(1'b0, 32, 3, 16'h0050, -1, 16'h0);
    // 0050 with leading-zero suppression, then without
    run_frame(1'b1, 32, -1, 16'h0, -1, 16'h0);
    run_frame(1'b0, 32, 7, 16'h0000, -1, 16'h0);
    // 0000 with suppression: only digit 0 lit; then 1000: all lit
    run_frame(1'b1, 32, 12, 16'h1000, -1, 16'h0);
    run_frame(1'b1, 32, -1, 16'h0, -1, 16'h0);
    // 1111 mid-frame overwritten by BEEF on the boundary edge
    run_frame(1'b0, 32, 10, 16'h1111, 31, 16'hBEEF);
    run_frame(1'b0, 32, -1, 16'h0, -1, 16'h0);

    // frame_start period on the no-blank instance
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 100);
    chk("fs_period_b", 32'(n), 32'd32);

    // Reset during ON of slot 2 with a load pending: outputs drop at once
    run_frame(1'b0, 21, 5, 16'hABCD, -1, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {22'd0, fs_a, valid_a, an_a, digit_a}, {22'd0, 10'b0_0_1111_0000});
    chk("async_rst_b", {22'd0, fs_b, valid_b, an_b, digit_b}, {22'd0, 10'b0_0_1111_0000});
    dp_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(16'h0000);
    run_frame(1'b0, 32, -1, 16'h0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
